// File: rtl/acc_ctrl_unit_if.sv
// Config, stream and status bundle of the accumulation controller.
// Carries res_valid_o only when MAGE_ACC_CTRL_RES_VALID_EN is defined.
interface acc_ctrl_unit_if #(
  parameter int N_ACC = 4,
  parameter int CNT_W = 16
);
  logic             cfg_we_i;
  logic [CNT_W-1:0] cfg_len_i;
  logic [CNT_W-1:0] cfg_nwin_i;
  logic [N_ACC-1:0] cfg_mask_i;
  logic [1:0]       vec_mode_i;
  logic             start_i;
  logic             stop_i;
  logic             stream_valid_i;
  logic [N_ACC-1:0] acc_match_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] win_cnt_o;
`ifdef MAGE_ACC_CTRL_RES_VALID_EN
  logic [N_ACC-1:0] res_valid_o;

  modport master (
    output cfg_we_i, cfg_len_i, cfg_nwin_i, cfg_mask_i,
    output vec_mode_i, start_i, stop_i, stream_valid_i,
    input  acc_match_o, busy_o, done_o, win_cnt_o, res_valid_o
  );
  modport slave (
    input  cfg_we_i, cfg_len_i, cfg_nwin_i, cfg_mask_i,
    input  vec_mode_i, start_i, stop_i, stream_valid_i,
    output acc_match_o, busy_o, done_o, win_cnt_o, res_valid_o
  );
`else
  modport master (
    output cfg_we_i, cfg_len_i, cfg_nwin_i, cfg_mask_i,
    output vec_mode_i, start_i, stop_i, stream_valid_i,
    input  acc_match_o, busy_o, done_o, win_cnt_o
  );
  modport slave (
    input  cfg_we_i, cfg_len_i, cfg_nwin_i, cfg_mask_i,
    input  vec_mode_i, start_i, stop_i, stream_valid_i,
    output acc_match_o, busy_o, done_o, win_cnt_o
  );
`endif
endinterface

// File: rtl/acc_ctrl_unit.sv
// Accumulation window sequencer driving per-PE acc_match strobes.
// MAGE_ACC_CTRL_RES_VALID_EN adds the delayed res_valid_o outputs.
module acc_ctrl_unit #(
  parameter int N_ACC = 4,
  parameter int CNT_W = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  acc_ctrl_unit_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_RUN, S_FLUSH, S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] nwin_q;
  logic [N_ACC-1:0] mask_q;
  logic [CNT_W-1:0] beat_q;
  logic [CNT_W-1:0] win_q;
  logic             stop_pend_q;

  logic [CNT_W-1:0] len_m1;
  logic [CNT_W-1:0] win_nx;
  logic             last;
  logic             open;
  logic             match;
  logic             win_end;

  // A length of 0 behaves as a length of 1
  assign len_m1 = (len_q == '0) ? '0 : len_q - 1'b1;
  assign last   = beat_q == len_m1;
  assign win_nx = (&win_q) ? win_q : win_q + 1'b1;

  assign win_end = ((nwin_q != '0) && (win_nx == nwin_q))
                 || stop_pend_q || bus.stop_i;

  assign open = (state_q == S_ARMED) && bus.stream_valid_i
              && !bus.stop_i;

  assign match = open
    || ((state_q == S_RUN) && bus.stream_valid_i && (beat_q == '0))
    || (state_q == S_FLUSH);

  assign bus.acc_match_o = {N_ACC{match}} & mask_q;
  assign bus.busy_o      = state_q != S_IDLE;
  assign bus.done_o      = state_q == S_DONE;
  assign bus.win_cnt_o   = win_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      len_q       <= CNT_W'(1);
      nwin_q      <= '0;
      mask_q      <= '0;
      beat_q      <= '0;
      win_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          stop_pend_q <= 1'b0;
          if (bus.cfg_we_i) begin
            len_q  <= bus.cfg_len_i;
            nwin_q <= bus.cfg_nwin_i;
            mask_q <= bus.cfg_mask_i;
          end
          if (bus.start_i) begin
            state_q <= S_ARMED;
            beat_q  <= '0;
            win_q   <= '0;
          end
        end
        S_ARMED, S_RUN: begin
          if (bus.stop_i)
            stop_pend_q <= 1'b1;
          // Stop before the first beat abandons the run silently
          if ((state_q == S_ARMED) && bus.stop_i) begin
            state_q <= S_IDLE;
          end else if (bus.stream_valid_i) begin
            if (last) begin
              beat_q  <= '0;
              win_q   <= win_nx;
              state_q <= win_end ? S_FLUSH : S_RUN;
            end else begin
              beat_q  <= beat_q + 1'b1;
              state_q <= S_RUN;
            end
          end
        end
        S_FLUSH: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MAGE_ACC_CTRL_RES_VALID_EN
  logic [3:0] dly_q;
  logic       dly_sel;
  logic       close;

  assign close = match && !open;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      dly_q <= '0;
    else
      dly_q <= {dly_q[2:0], close};
  end

  // Result latency follows the PE pipeline depth per vector mode
  always_comb begin
    dly_sel = dly_q[0];
    unique case (bus.vec_mode_i)
      2'b01:   dly_sel = dly_q[3];
      2'b10:   dly_sel = dly_q[2];
      default: dly_sel = dly_q[0];
    endcase
  end

  assign bus.res_valid_o = {N_ACC{dly_sel}} & mask_q;
`else
  logic unused_vec;
  assign unused_vec = ^bus.vec_mode_i;
`endif
endmodule

// File: tb/tb_acc_ctrl_unit.sv
// Vector-table and scoreboard bench for acc_ctrl_unit.
// Covers the res_valid path when MAGE_ACC_CTRL_RES_VALID_EN is defined.
module tb_acc_ctrl_unit;
  localparam int N = 4;
  localparam int W = 16;
  localparam int NC = 20;

  logic clk;
  logic rst;

  acc_ctrl_unit_if #(.N_ACC(N), .CNT_W(W)) bus ();

  acc_ctrl_unit #(.N_ACC(N), .CNT_W(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   len;
    logic [15:0]   nwin;
    logic [3:0]    mask;
    logic [NC-1:0] vpat;
    logic [NC-1:0] spat;
    logic [NC-1:0] mexp;
    logic [NC-1:0] dexp;
    logic [15:0]   wexp;
  } vec_t;

  typedef struct {
    logic [3:0] m;
    logic       d;
  } exp_t;

  vec_t tv[7];
  exp_t sbq[$];
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] len,
                           input logic [15:0] nwin,
                           input logic [3:0] mask,
                           input logic we);
    @(posedge clk); #1;
    bus.cfg_len_i  = len;
    bus.cfg_nwin_i = nwin;
    bus.cfg_mask_i = mask;
    bus.cfg_we_i   = we;
    bus.start_i    = 1'b1;
    @(posedge clk); #1;
    bus.cfg_we_i   = 1'b0;
    bus.start_i    = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    exp_t e;
    v = tv[idx];
    start_run(v.len, v.nwin, v.mask, 1'b1);
    for (int k = 0; k < NC; k++) begin
      bus.stream_valid_i = v.vpat[k];
      bus.stop_i         = v.spat[k];
      e.m = v.mexp[k] ? v.mask : 4'h0;
      e.d = v.dexp[k];
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("v%0d.k%0d.match", idx, k),
          32'(bus.acc_match_o), 32'(e.m));
      chk($sformatf("v%0d.k%0d.done", idx, k),
          32'(bus.done_o), 32'(e.d));
      @(posedge clk); #1;
    end
    bus.stream_valid_i = 1'b0;
    bus.stop_i         = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d.win", idx), 32'(bus.win_cnt_o), 32'(v.wexp));
    chk($sformatf("v%0d.busy", idx), 32'(bus.busy_o), 32'd0);
  endtask

`ifdef MAGE_ACC_CTRL_RES_VALID_EN
  task automatic run_rv(input logic [1:0] mode, input logic [3:0] mask,
                        input logic [NC-1:0] rexp);
    bus.vec_mode_i = mode;
    start_run(16'd2, 16'd2, mask, 1'b1);
    for (int k = 0; k < 13; k++) begin
      bus.stream_valid_i = 1'b1;
      @(negedge clk);
      chk($sformatf("rv%0d.k%0d", mode, k), 32'(bus.res_valid_o),
          32'(rexp[k] ? mask : 4'h0));
      @(posedge clk); #1;
    end
    bus.stream_valid_i = 1'b0;
    bus.vec_mode_i     = 2'b00;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    tv[0] = '{16'd4, 16'd2, 4'b0101, 20'hFFFFF, 20'h0,
              20'h00111, 20'h00200, 16'd2};
    tv[1] = '{16'd3, 16'd1, 4'b1111, 20'h00025, 20'h0,
              20'h00041, 20'h00080, 16'd1};
    tv[2] = '{16'd1, 16'd3, 4'b0011, 20'hFFFFF, 20'h0,
              20'h0000F, 20'h00010, 16'd3};
    tv[3] = '{16'd0, 16'd3, 4'b0011, 20'hFFFFF, 20'h0,
              20'h0000F, 20'h00010, 16'd3};
    tv[4] = '{16'd2, 16'd1, 4'b1000, 20'hFFFFC, 20'h0,
              20'h00014, 20'h00020, 16'd1};
    tv[5] = '{16'd5, 16'd0, 4'b1111, 20'hFFFFF, 20'h00800,
              20'h08421, 20'h10000, 16'd3};
    tv[6] = '{16'd3, 16'd2, 4'b1111, 20'hFFFFC, 20'h00002,
              20'h00000, 20'h00000, 16'd0};

    rst                = 1'b1;
    bus.cfg_we_i       = 1'b0;
    bus.cfg_len_i      = '0;
    bus.cfg_nwin_i     = '0;
    bus.cfg_mask_i     = '0;
    bus.vec_mode_i     = 2'b00;
    bus.start_i        = 1'b0;
    bus.stop_i         = 1'b0;
    bus.stream_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.match", 32'(bus.acc_match_o), 32'd0);
    chk("rst.busy", 32'(bus.busy_o), 32'd0);
    chk("rst.done", 32'(bus.done_o), 32'd0);
    chk("rst.win", 32'(bus.win_cnt_o), 32'd0);
`ifdef MAGE_ACC_CTRL_RES_VALID_EN
    chk("rst.rv", 32'(bus.res_valid_o), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_vec(i);

    // Reset mid-run with beat_q == 2, then restart on reset config
    start_run(16'd4, 16'd0, 4'b1111, 1'b1);
    bus.stream_valid_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid.match", 32'(bus.acc_match_o), 32'd0);
    chk("mid.busy", 32'(bus.busy_o), 32'd0);
    chk("mid.done", 32'(bus.done_o), 32'd0);
    chk("mid.win", 32'(bus.win_cnt_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.stream_valid_i = 1'b0;
    start_run(16'd9, 16'd9, 4'b1111, 1'b0);
    for (int k = 0; k < 10; k++) begin
      bus.stream_valid_i = 1'b1;
      bus.stop_i         = (k == 5);
      @(negedge clk);
      chk($sformatf("post.k%0d.match", k),
          32'(bus.acc_match_o), 32'd0);
      chk($sformatf("post.k%0d.done", k),
          32'(bus.done_o), 32'(k == 7));
      @(posedge clk); #1;
    end
    bus.stream_valid_i = 1'b0;
    bus.stop_i         = 1'b0;
    @(negedge clk);
    chk("post.win", 32'(bus.win_cnt_o), 32'd6);
    chk("post.busy", 32'(bus.busy_o), 32'd0);

`ifdef MAGE_ACC_CTRL_RES_VALID_EN
    run_rv(2'b01, 4'b1111, 20'h00140);
    run_rv(2'b10, 4'b0110, 20'h000A0);
    run_rv(2'b00, 4'b1001, 20'h00028);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/acc_ctrl_unit.md
# acc_ctrl_unit

Accumulation controller that sequences the accumulation PEs of the PEA. It counts valid stream beats against a configured window length and window count, and drives the per-PE `acc_match` strobes. Each strobe marks the first operand of a new accumulation window, which is also the close of the previous one. It sits next to the PE array, is configured by the PEA control logic, and fans out one strobe per accumulation-capable PE, gated by a channel mask.

## Interface
Parameters:
- `N_ACC`, default 4: number of accumulation PE channels driven.
- `CNT_W`, default 16: width of the window-length and window-count fields.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `cfg_we_i` in 1: latch configuration. Honoured only in IDLE.
- `cfg_len_i` in CNT_W: beats per window L. 0 is treated as 1.
- `cfg_nwin_i` in CNT_W: number of windows W. 0 means run until `stop_i`.
- `cfg_mask_i` in N_ACC: channel enable mask.
- `vec_mode_i` in 2: PE vector mode. 00 = 32b, 01 = 8b, 10 = 16b.
- `start_i` in 1: arm the controller. Honoured only in IDLE.
- `stop_i` in 1: request termination at the end of the current window.
- `stream_valid_i` in 1: a valid operand beat is present at the PE inputs this cycle.
- `acc_match_o` out N_ACC: accumulation match strobe per channel.
- `busy_o` out 1: state is not IDLE.
- `done_o` out 1: one-cycle pulse on completion.
- `win_cnt_o` out CNT_W: number of windows completed in the current run.
- `res_valid_o` out N_ACC: result-valid per channel. Present only with the macro enabled.

## Operation
- Configuration registers are `len_q`, `nwin_q` and `mask_q`. They are written on `cfg_we_i` in IDLE and held otherwise. Their reset values are L = 1, W = 0 and mask = 0.
- Beat counter `beat_q` runs from 0 to L-1. Window counter `win_q` runs from 0 to W.
- Internal `match` signal (combinational from registered state and `stream_valid_i`):
  - (ARMED or RUN) and `stream_valid_i` and `beat_q` == 0, or
  - state == FLUSH, regardless of `stream_valid_i`.
- `acc_match_o[i]` = `match` & `mask_q[i]`.
- States:
  - IDLE: on `start_i`, go to ARMED. `beat_q` and `win_q` are cleared to 0.
  - ARMED: waiting for the first beat. On a valid beat: assert `match` (the first window opens, no result yet), set `beat_q` to 1 (or 0 if L = 1), go to RUN.
  - RUN: on each valid beat, `beat_q` increments and wraps from L-1 to 0.
    - On a wrapping beat: `win_q`++.
    - If the new `win_q` == W (W != 0), or a stop is pending, go to FLUSH.
    - Otherwise the next valid beat, with `beat_q` == 0, raises `match`.
    - Invalid cycles hold all counters.
  - FLUSH: one cycle. `match` closes the last window so the PE captures its sum. Next state is DONE.
  - DONE: one cycle. `done_o` = 1. Next state is IDLE.
- Stop handling:
  - `stop_i` sets a sticky `stop_pend_q` in ARMED or RUN. It is cleared in IDLE.
  - `stop_i` in ARMED goes to IDLE directly, with no strobes and no `done_o`.
  - `stop_i` in IDLE, FLUSH or DONE is ignored.
- Counter widths:
  - `win_q` saturates at 2^CNT_W-1 when W = 0.
  - `beat_q` comparisons use the full CNT_W width. L = 2^CNT_W-1 is legal.
- `win_cnt_o` = `win_q`.

## Timing
- `acc_match_o` has zero latency: it is valid in the same cycle as the qualifying `stream_valid_i` beat.
- `match` strobes are single-cycle. Back-to-back strobes occur when L = 1 and `stream_valid_i` stays high.
- Total strobes per completed run is W+1: the open strobe, one per window boundary, and the flush strobe.
- `cfg_we_i` together with `start_i` in IDLE: the new configuration applies to the run being started.
- `start_i` while `busy_o` = 1 is ignored.
- Reset asserted mid-run: on the next edge the state is IDLE, all counters are 0, `stop_pend_q` is 0, the configuration returns to its reset values, and all outputs are 0. No flush strobe is issued.
- Reset values: `acc_match_o` = 0, `busy_o` = 0, `done_o` = 0, `win_cnt_o` = 0, `res_valid_o` = 0.

## Configuration
- `MAGE_ACC_CTRL_RES_VALID_EN` defined:
  - A shift register delays every non-opening `match` by a latency set by `vec_mode_i`: 1 cycle for 00, 3 cycles for 10, 4 cycles for 01.
  - `res_valid_o[i]` = delayed `match` & `mask_q[i]`. It marks the cycle in which the PE output holds a completed window result.
  - The pipeline clears on `rst_i`.
  - A flush strobe still produces `res_valid_o` after the controller returns to IDLE.
- Macro undefined: the `res_valid_o` port and the delay logic are absent.

## Test plan
- Basic run: L = 4, W = 2, mask = 4'b0101, valid every cycle from cycle 10. Required: `acc_match_o` = 0101 at cycles 10, 14 and 18 (flush). `done_o` pulses at cycle 19. `win_cnt_o` = 2.
- Bubbles: L = 3, W = 1, valid pattern 1,0,1,0,0,1. Required: a strobe on the first valid beat, then the flush strobe the cycle after the third valid beat. Counters hold during bubbles.
- L = 1 / L = 0 edge: W = 3, continuous valid. Required: strobes on 3 consecutive beats plus flush, 4 strobes total, identical for L = 0 and L = 1.
- Stop: W = 0, L = 5, `stop_i` pulsed on the 2nd beat of window 3. Required: window 3 completes, then flush, `done_o`, `win_cnt_o` = 3. A separate case pulses `stop_i` in ARMED. Required: return to IDLE with no strobe and no `done_o`.
- Reset mid-run: assert `rst_i` during RUN with `beat_q` = 2. Required: the next cycle has all outputs 0 and `busy_o` = 0. The following `start_i` begins from the reset configuration (L = 1, mask = 0), so no strobes are visible.
- Macro enabled: `vec_mode_i` = 01, L = 2, W = 2. Required: `res_valid_o` is high 4 cycles after the 2nd strobe and 4 cycles after the flush strobe. The opening strobe produces no `res_valid_o`.
